// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch-mispredict flush, RET fetch hold and HALT.
// Optional performance counters are enabled by defining PIPE_PERF_EN.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  D_icode,
   input  logic [7:0]  d_srcA,
   input  logic [7:0]  d_srcB,
   input  logic [7:0]  E_icode,
   input  logic [7:0]  E_dstM,
   input  logic        e_cnd,
   input  logic        W_halt,
   output logic        F_stall,
   output logic        D_stall,
   output logic        D_bubble,
   output logic        E_bubble,
   output logic        halted,
   output logic [31:0] stall_cnt,
   output logic [31:0] mispred_cnt
);

   localparam logic [7:0] IC_MRMOVL = 8'h05;
   localparam logic [7:0] IC_JXX    = 8'h07;
   localparam logic [7:0] IC_RET    = 8'h09;
   localparam logic [7:0] IC_POPL   = 8'h0B;
   localparam logic [7:0] RNONE     = 8'h0F;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_RET  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t     state_r, state_s;
   logic [1:0] ret_cnt_r, ret_cnt_s;
   logic       load_use_s, mispred_s;
   logic       f_stall_s, d_stall_s, d_bubble_s, e_bubble_s, halted_s;

   assign load_use_s = ((E_icode == IC_MRMOVL) || (E_icode == IC_POPL)) && (E_dstM != RNONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
   assign mispred_s  = (E_icode == IC_JXX) && !e_cnd;

   // Next-state and control decode, with reset forcing the flush pattern on the outputs
   always_comb begin
      state_s    = state_r;
      ret_cnt_s  = ret_cnt_r;
      f_stall_s  = 1'b0;
      d_stall_s  = 1'b0;
      d_bubble_s = 1'b0;
      e_bubble_s = 1'b0;
      halted_s   = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (W_halt) begin
               f_stall_s  = 1'b1;
               d_stall_s  = 1'b1;
               e_bubble_s = 1'b1;
               halted_s   = 1'b1;
               state_s    = ST_HALT;
            end else if (mispred_s) begin
               // The flushed D slot may hold a RET; it must not start the RET hold
               d_bubble_s = 1'b1;
               e_bubble_s = 1'b1;
            end else if (load_use_s) begin
               f_stall_s  = 1'b1;
               d_stall_s  = 1'b1;
               e_bubble_s = 1'b1;
            end else if (D_icode == IC_RET) begin
               f_stall_s  = 1'b1;
               d_bubble_s = 1'b1;
               state_s    = ST_RET;
               ret_cnt_s  = 2'd2;
            end else begin
               state_s    = ST_RUN;
            end
         end
         ST_RET: begin
            if (W_halt) begin
               f_stall_s  = 1'b1;
               d_stall_s  = 1'b1;
               e_bubble_s = 1'b1;
               halted_s   = 1'b1;
               state_s    = ST_HALT;
            end else begin
               f_stall_s  = 1'b1;
               d_bubble_s = 1'b1;
               ret_cnt_s  = ret_cnt_r - 2'd1;
               // A count of 0 here is corrupt; return to RUN rather than wrap
               if (ret_cnt_r <= 2'd1) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_RET;
               end
            end
         end
         ST_HALT: begin
            f_stall_s  = 1'b1;
            d_stall_s  = 1'b1;
            e_bubble_s = 1'b1;
            halted_s   = 1'b1;
            state_s    = ST_HALT;
         end
         default: begin
            d_bubble_s = 1'b1;
            e_bubble_s = 1'b1;
            state_s    = ST_RUN;
            ret_cnt_s  = 2'd0;
         end
      endcase

      if (rst) begin
         F_stall  = 1'b0;
         D_stall  = 1'b0;
         D_bubble = 1'b1;
         E_bubble = 1'b1;
         halted   = 1'b0;
      end else begin
         F_stall  = f_stall_s;
         D_stall  = d_stall_s;
         D_bubble = d_bubble_s;
         E_bubble = e_bubble_s;
         halted   = halted_s;
      end
   end

   // Controller state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_RUN;
         ret_cnt_r <= 2'd0;
      end else begin
         state_r   <= state_s;
         ret_cnt_r <= ret_cnt_s;
      end
   end

`ifdef PIPE_PERF_EN
   logic [31:0] stall_cnt_r, mispred_cnt_r;
   logic        stall_inc_s, mispred_inc_s;

   assign stall_inc_s   = f_stall_s && !halted_s;
   assign mispred_inc_s = mispred_s && !halted_s;

   // Saturating performance counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r   <= 32'h0;
         mispred_cnt_r <= 32'h0;
      end else begin
         if (stall_inc_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (mispred_inc_s && (mispred_cnt_r != 32'hFFFF_FFFF)) begin
            mispred_cnt_r <= mispred_cnt_r + 32'd1;
         end else begin
            mispred_cnt_r <= mispred_cnt_r;
         end
      end
   end

   assign stall_cnt   = stall_cnt_r;
   assign mispred_cnt = mispred_cnt_r;
`else
   assign stall_cnt   = 32'h0;
   assign mispred_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected controls/counters are queued per cycle and
// compared at the falling edge. Honours PIPE_PERF_EN for counter expectations.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic [7:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM;
   logic        e_cnd, W_halt;
   logic        F_stall, D_stall, D_bubble, E_bubble, halted;
   logic [31:0] stall_cnt, mispred_cnt;

   typedef struct {
      string       name;
      logic [4:0]  ctl;
      logic [31:0] sc;
      logic [31:0] mc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_sc = 32'h0;
   logic [31:0] m_mc = 32'h0;

   localparam logic [4:0] C_NORM = 5'b00000;
   localparam logic [4:0] C_RST  = 5'b00110;
   localparam logic [4:0] C_MIS  = 5'b00110;
   localparam logic [4:0] C_LU   = 5'b11010;
   localparam logic [4:0] C_RET  = 5'b10100;
   localparam logic [4:0] C_HALT = 5'b11011;

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .W_halt(W_halt),
      .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
      .halted(halted), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs right after the rising edge and queue what must be seen
   task automatic step(input string name, input logic r, input logic [7:0] di,
                       input logic [7:0] sa, input logic [7:0] sbb, input logic [7:0] ei,
                       input logic [7:0] ed, input logic ec, input logic wh, input logic [4:0] ctl);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; D_icode = di; d_srcA = sa; d_srcB = sbb;
      E_icode = ei; E_dstM = ed; e_cnd = ec; W_halt = wh;
      x.name = name; x.ctl = ctl; x.sc = m_sc; x.mc = m_mc;
      sb.push_back(x);
`ifdef PIPE_PERF_EN
      if (r) begin
         m_sc = 32'h0;
         m_mc = 32'h0;
      end else begin
         if (ctl[4] && !ctl[0]) m_sc = m_sc + 32'd1;
         if ((ei == 8'h07) && !ec && !ctl[0]) m_mc = m_mc + 32'd1;
      end
`endif
   endtask

   task automatic idle(input string name, input logic [4:0] ctl);
      step(name, 1'b0, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, ctl);
   endtask

   // Compare queued expectations against outputs, plus control-word invariants
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         e = sb.pop_front();
         checks = checks + 1;
         if ({F_stall, D_stall, D_bubble, E_bubble, halted} !== e.ctl) begin
            errors = errors + 1;
            $display("FAIL %s ctl(F_stall,D_stall,D_bubble,E_bubble,halted) actual=%b required=%b",
                     e.name, {F_stall, D_stall, D_bubble, E_bubble, halted}, e.ctl);
         end
         checks = checks + 1;
         if (stall_cnt !== e.sc) begin
            errors = errors + 1;
            $display("FAIL %s stall_cnt actual=%0d required=%0d", e.name, stall_cnt, e.sc);
         end
         checks = checks + 1;
         if (mispred_cnt !== e.mc) begin
            errors = errors + 1;
            $display("FAIL %s mispred_cnt actual=%0d required=%0d", e.name, mispred_cnt, e.mc);
         end
         checks = checks + 1;
         if ((D_stall && D_bubble) || (F_stall && !(D_stall || D_bubble))) begin
            errors = errors + 1;
            $display("FAIL %s invariant actual=F%b Ds%b Db%b required=no Ds&Db, F implies Ds|Db",
                     e.name, F_stall, D_stall, D_bubble);
         end
      end
   end

   task automatic test_reset();
      step("reset0", 1'b1, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RST);
      step("reset_ret_in_d", 1'b1, 8'h09, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1'b0, 1'b0, C_RST);
      idle("after_reset", C_NORM);
   endtask

   task automatic test_load_use();
      step("lu_srcB", 1'b0, 8'h06, 8'h01, 8'h03, 8'h05, 8'h03, 1'b0, 1'b0, C_LU);
      idle("lu_release", C_NORM);
      step("lu_popl_srcA", 1'b0, 8'h06, 8'h04, 8'h02, 8'h0B, 8'h04, 1'b0, 1'b0, C_LU);
      step("lu_rnone", 1'b0, 8'h06, 8'h0F, 8'h0F, 8'h05, 8'h0F, 1'b0, 1'b0, C_NORM);
      step("lu_no_match", 1'b0, 8'h06, 8'h01, 8'h02, 8'h05, 8'h03, 1'b0, 1'b0, C_NORM);
      step("lu_wrong_icode", 1'b0, 8'h06, 8'h03, 8'h03, 8'h04, 8'h03, 1'b0, 1'b0, C_NORM);
   endtask

   task automatic test_ret();
      step("ret_d", 1'b0, 8'h09, 8'h04, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RET);
      idle("ret_hold2", C_RET);
      idle("ret_hold3", C_RET);
      idle("ret_done", C_NORM);
      step("ret_lu", 1'b0, 8'h09, 8'h04, 8'h0F, 8'h05, 8'h04, 1'b0, 1'b0, C_LU);
      step("ret_after_lu", 1'b0, 8'h09, 8'h04, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RET);
      idle("ret_after_lu2", C_RET);
      idle("ret_after_lu3", C_RET);
      idle("ret_after_lu_done", C_NORM);
   endtask

   task automatic test_mispred();
      step("mis_ret", 1'b0, 8'h09, 8'h04, 8'h0F, 8'h07, 8'h0F, 1'b0, 1'b0, C_MIS);
      idle("mis_no_ret_seq", C_NORM);
      step("jxx_taken", 1'b0, 8'h09, 8'h04, 8'h0F, 8'h07, 8'h0F, 1'b1, 1'b0, C_RET);
      idle("jxx_taken_r2", C_RET);
      idle("jxx_taken_r3", C_RET);
      step("mis_lu", 1'b0, 8'h06, 8'h03, 8'h03, 8'h07, 8'h03, 1'b0, 1'b0, C_MIS);
      idle("mis_release", C_NORM);
   endtask

   task automatic test_back_to_back();
      step("b2b_ret1", 1'b0, 8'h09, 8'h04, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RET);
      idle("b2b_r2", C_RET);
      idle("b2b_r3", C_RET);
      step("b2b_ret2", 1'b0, 8'h09, 8'h04, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RET);
      idle("b2b_r2b", C_RET);
      step("reset_mid_ret", 1'b1, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RST);
      idle("post_mid_ret_reset", C_NORM);
      idle("post_mid_ret_reset2", C_NORM);
   endtask

   task automatic test_halt();
      step("halt_w", 1'b0, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b1, C_HALT);
      idle("halt_hold1", C_HALT);
      step("halt_hold_ret", 1'b0, 8'h09, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1'b0, 1'b0, C_HALT);
      idle("halt_hold3", C_HALT);
      step("halt_reset", 1'b1, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RST);
      idle("halt_cleared", C_NORM);
      step("halt_over_mis", 1'b0, 8'h09, 8'h0F, 8'h0F, 8'h07, 8'h0F, 1'b0, 1'b1, C_HALT);
      idle("halt_over_mis_hold", C_HALT);
      step("halt_reset2", 1'b1, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RST);
      step("ret_then_halt", 1'b0, 8'h09, 8'h04, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RET);
      step("halt_in_ret", 1'b0, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b1, C_HALT);
      idle("halt_in_ret_hold", C_HALT);
      step("halt_reset3", 1'b1, 8'h01, 8'h0F, 8'h0F, 8'h01, 8'h0F, 1'b0, 1'b0, C_RST);
      idle("final_norm", C_NORM);
   endtask

   initial begin
      rst = 1'b1; D_icode = 8'h01; d_srcA = 8'h0F; d_srcB = 8'h0F;
      E_icode = 8'h01; E_dstM = 8'h0F; e_cnd = 1'b0; W_halt = 1'b0;
      test_reset();
      test_load_use();
      test_ret();
      test_mispred();
      test_back_to_back();
      test_halt();
      @(negedge clk);
      #1;
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain queue_size actual=%0d required=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
